// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Control, program-load and IF/ID signal bundle for fetch_stage.
//               master drives stall/redirect/program-load and observes the
//               IF/ID outputs; slave is the fetch stage itself.
//   stall        hold PC and IF/ID register
//   redirect     taken branch/jump, loads redirect_pc and flushes IF/ID
//   redirect_pc  new fetch address
//   imem_we      program-load write enable
//   imem_waddr   program-load word address
//   imem_wdata   program-load word
//   pc           current fetch address
//   instruction  IF/ID instruction register
//   pc_plus1     IF/ID copy of fetched address + 1
//   instr_valid  IF/ID holds a real fetched instruction
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  stall;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [15:0]           imem_wdata;
  logic [ADDR_WIDTH-1:0] pc;
  logic [15:0]           instruction;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic                  instr_valid;

  modport master (
    output stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
    input  pc, instruction, pc_plus1, instr_valid
  );

  modport slave (
    input  stall, redirect, redirect_pc, imem_we, imem_waddr, imem_wdata,
    output pc, instruction, pc_plus1, instr_valid
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Holds the PC and a word-addressed
//               16-bit instruction memory, and registers each fetched word
//               into the IF/ID pipeline register for the decoding stage.
// Ports       :
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    fetch_stage_if.slave (stall, redirect, program-load write port,
//          registered pc / instruction / pc_plus1 / instr_valid outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int                  ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [15:0]         NOP        = 16'h0000
) (
  input  wire logic    clk,
  input  wire logic    reset,
  fetch_stage_if.slave bus
);

  localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [15:0]           r_mem [0:c_DEPTH-1];
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_instruction;
  logic [ADDR_WIDTH-1:0] r_pc_plus1;
  logic                  r_instr_valid;

  logic [15:0]           w_fetch_word;
  logic [ADDR_WIDTH-1:0] w_pc_inc;

  // Combinational read; a same-edge write is not forwarded, so IF/ID sees
  // the old word and the new one becomes visible on the following cycle.
  assign w_fetch_word = r_mem[r_pc];
  // Natural wrap of the ADDR_WIDTH-bit sum gives modulo-2^N PC arithmetic.
  assign w_pc_inc     = r_pc + c_ONE;

  // Program-load port is deliberately independent of reset/stall/redirect,
  // so a program can be loaded while the pipeline is held in reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      r_mem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_instruction <= NOP;
      r_pc_plus1    <= '0;
      r_instr_valid <= 1'b0;
    end else if (bus.redirect) begin
      // Redirect beats stall; pc_plus1 keeps its previous value.
      r_pc          <= bus.redirect_pc;
      r_instruction <= NOP;
      r_instr_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc          <= w_pc_inc;
      r_instruction <= w_fetch_word;
      r_pc_plus1    <= w_pc_inc;
      r_instr_valid <= 1'b1;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.instruction = r_instruction;
  assign bus.pc_plus1    = r_pc_plus1;
  assign bus.instr_valid = r_instr_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage (ADDR_WIDTH = 4):
//               directed scenarios followed by randomized cycles, all
//               compared against a behavioural model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_stage_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_stage #(
    .ADDR_WIDTH (AW),
    .RESET_PC   ('0),
    .NOP        (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_mem [DEPTH];
  int m_pc;
  int m_instr;
  int m_pp1;
  int m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge: advance the model from the current inputs, clock the
  // DUT, then compare every output just after the edge.
  task automatic step();
    int word;
    word = m_mem[m_pc];
    if (reset) begin
      m_pc = 0; m_instr = 0; m_pp1 = 0; m_valid = 0;
    end else if (bus.redirect) begin
      m_pc = int'(bus.redirect_pc); m_instr = 0; m_valid = 0;
    end else if (!bus.stall) begin
      m_instr = word;
      m_pp1   = (m_pc + 1) % DEPTH;
      m_pc    = (m_pc + 1) % DEPTH;
      m_valid = 1;
    end
    if (bus.imem_we) m_mem[int'(bus.imem_waddr)] = int'(bus.imem_wdata);
    @(posedge clk);
    #1;
    check("m_pc",    32'(bus.pc),          32'(m_pc));
    check("m_instr", 32'(bus.instruction), 32'(m_instr));
    check("m_pp1",   32'(bus.pc_plus1),    32'(m_pp1));
    check("m_valid", 32'(bus.instr_valid), 32'(m_valid));
  endtask

  task automatic idle();
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    bus.imem_we = 0; bus.imem_waddr = '0; bus.imem_wdata = '0;
  endtask

  logic [15:0] prog [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 16'h6401; prog[1] = 16'h65BF; prog[2] = 16'h1234; prog[3] = 16'hABCD;
    m_pc = 0; m_instr = 0; m_pp1 = 0; m_valid = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    idle();
    reset = 1;

    // Program load under reset; remaining words randomised
    for (int i = 0; i < DEPTH; i++) begin
      bus.imem_we    = 1;
      bus.imem_waddr = AW'(i);
      bus.imem_wdata = (i < 4) ? prog[i] : 16'($urandom_range(0, 65535));
      step();
    end
    idle();
    step();
    check("rst_pc",    32'(bus.pc), 0);
    check("rst_instr", 32'(bus.instruction), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);

    // Straight-line fetch
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("sl_instr", 32'(bus.instruction), 32'(prog[i]));
      check("sl_pp1",   32'(bus.pc_plus1),    32'(i + 1));
      check("sl_valid", 32'(bus.instr_valid), 1);
    end
    check("sl_pc", 32'(bus.pc), 4);

    // Back to 0, then stall while 65BF is in IF/ID
    bus.redirect = 1; bus.redirect_pc = '0;
    step();
    check("rd0_instr", 32'(bus.instruction), 0);
    check("rd0_valid", 32'(bus.instr_valid), 0);
    check("rd0_pc",    32'(bus.pc), 0);
    bus.redirect = 0;
    step();
    step();
    check("st_pre", 32'(bus.instruction), 32'h65BF);
    bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("st_instr", 32'(bus.instruction), 32'h65BF);
      check("st_pc",    32'(bus.pc), 2);
      check("st_pp1",   32'(bus.pc_plus1), 2);
    end
    bus.stall = 0;
    step();
    check("st_after", 32'(bus.instruction), 32'h1234);
    check("st_pc3",   32'(bus.pc), 3);

    // Redirect at pc = 3
    bus.redirect = 1; bus.redirect_pc = '0;
    step();
    check("rd_instr", 32'(bus.instruction), 0);
    check("rd_valid", 32'(bus.instr_valid), 0);
    check("rd_pc",    32'(bus.pc), 0);
    bus.redirect = 0;
    step();
    check("rd_next",  32'(bus.instruction), 32'h6401);
    check("rd_nvld",  32'(bus.instr_valid), 1);

    // Redirect and stall together
    bus.redirect = 1; bus.stall = 1; bus.redirect_pc = 4'd2;
    step();
    check("rs_pc",    32'(bus.pc), 2);
    check("rs_instr", 32'(bus.instruction), 0);
    check("rs_valid", 32'(bus.instr_valid), 0);
    bus.redirect = 0;

    // Wrap-around: load mem[15] during a stall, redirect to 15
    bus.imem_we = 1; bus.imem_waddr = 4'd15; bus.imem_wdata = 16'h00FF;
    step();
    bus.imem_we = 0; bus.stall = 0;
    bus.redirect = 1; bus.redirect_pc = 4'd15;
    step();
    bus.redirect = 0;
    step();
    check("wr_instr", 32'(bus.instruction), 32'h00FF);
    check("wr_pp1",   32'(bus.pc_plus1), 0);
    check("wr_pc",    32'(bus.pc), 0);

    // Reset mid-run at pc = 2
    step();
    step();
    check("mr_pre_pc", 32'(bus.pc), 2);
    reset = 1;
    step();
    check("mr_pc",    32'(bus.pc), 0);
    check("mr_instr", 32'(bus.instruction), 0);
    check("mr_valid", 32'(bus.instr_valid), 0);
    reset = 0;
    step();
    check("mr_mem0", 32'(bus.instruction), 32'h6401);

    // Read-during-write at pc = 1
    bus.imem_we = 1; bus.imem_waddr = 4'd1; bus.imem_wdata = 16'hBEEF;
    step();
    check("rdw_old", 32'(bus.instruction), 32'h65BF);
    bus.imem_we = 0;
    bus.redirect = 1; bus.redirect_pc = 4'd1;
    step();
    bus.redirect = 0;
    step();
    check("rdw_new", 32'(bus.instruction), 32'hBEEF);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      reset           = ($urandom_range(0, 19) == 0);
      bus.redirect    = ($urandom_range(0, 5) == 0);
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.redirect_pc = AW'($urandom_range(0, DEPTH - 1));
      bus.imem_we     = ($urandom_range(0, 2) == 0);
      bus.imem_waddr  = ($urandom_range(0, 1) == 0) ? bus.pc : AW'($urandom_range(0, DEPTH - 1));
      bus.imem_wdata  = 16'($urandom_range(0, 65535));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
